// File: rtl/sha256_stream_hasher_pkg.sv
// SHA-256 shared definitions: round constants, initial hash value, FSM
// state encoding and the bitwise helper functions used by the rounds.
package sha256_pkg;

  typedef logic [31:0]     word_t;
  typedef word_t [0:7]     hstate_t;   // element 0 = a / H0
  typedef word_t [0:15]    window_t;   // element 0 = oldest schedule word

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUND  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  localparam hstate_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Stream bytes are little-end-first; SHA-256 words are big-endian.
  function automatic word_t bswap32(input word_t x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/sha256_stream_hasher_if.sv
// AXI4-stream style bundle used for both the block sink and digest source.
interface AXI4SR #(
  parameter int DATA_W = 512,
  parameter int ID_W   = 8
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic [ID_W-1:0]     tid;

  modport m (output tdata, tkeep, tvalid, tlast, tid, input tready);
  modport s (input tdata, tkeep, tvalid, tlast, tid, output tready);
endinterface

// File: rtl/sha256_stream_hasher_round_unit.sv
// Combinational SHA-256 compression step: ROUNDS_PER_CYCLE rounds chained,
// each consuming the oldest window word and appending the next schedule word.
module sha256_round_unit
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  hstate_t    state_i,
  input  window_t    window_i,
  input  logic [5:0] round_i,
  output hstate_t    state_o,
  output window_t    window_o
);

  hstate_t st [0:ROUNDS_PER_CYCLE];
  window_t wn [0:ROUNDS_PER_CYCLE];

  assign st[0] = state_i;
  assign wn[0] = window_i;

  generate
    for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
      logic [5:0] idx;
      word_t      t1;
      word_t      t2;
      word_t      w_new;

      assign idx   = round_i + 6'(gi);
      assign t1    = st[gi][7] + bsig1(st[gi][4]) + ch(st[gi][4], st[gi][5], st[gi][6])
                   + K[idx] + wn[gi][0];
      assign t2    = bsig0(st[gi][0]) + maj(st[gi][0], st[gi][1], st[gi][2]);
      assign w_new = ssig1(wn[gi][14]) + wn[gi][9] + ssig0(wn[gi][1]) + wn[gi][0];

      assign st[gi+1] = {t1 + t2, st[gi][0], st[gi][1], st[gi][2],
                         st[gi][3] + t1, st[gi][4], st[gi][5], st[gi][6]};
      assign wn[gi+1] = {wn[gi][1:15], w_new};
    end
  endgenerate

  assign state_o  = st[ROUNDS_PER_CYCLE];
  assign window_o = wn[ROUNDS_PER_CYCLE];

endmodule

// File: rtl/sha256_stream_hasher.sv
// Multi-message SHA-256 stream hasher. Accepts pre-padded 512-bit blocks,
// chains H across a message and emits one digest per message through a
// small buffer with a registered output stage.
// Optional: define SHA256_STATS_EN to enable the block/message counters.
module sha256_stream_hasher
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int OUT_FIFO_DEPTH   = 4,
  parameter int CNT_BITS         = 32,
  parameter int ID_W             = 8
) (
  input  logic                aclk,
  input  logic                areset,
  AXI4SR.s                    axis_sink,
  AXI4SR.m                    axis_src,
  output logic                busy,
  output logic [CNT_BITS-1:0] msg_count,
  output logic [CNT_BITS-1:0] blk_count
);

  localparam int PW = $clog2(OUT_FIFO_DEPTH);
  localparam int CW = PW + 1;

  state_e          state_q;
  hstate_t         h_q;
  hstate_t         work_q;
  hstate_t         work_d;
  window_t         win_q;
  window_t         win_d;
  window_t         blk_words;
  hstate_t         h_sum;
  logic [5:0]      rnd_q;
  logic            last_q;
  logic            in_msg_q;
  logic [ID_W-1:0] tid_q;
  logic [255:0]    digest;

  logic [ID_W+255:0] mem_q [0:OUT_FIFO_DEPTH-1];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     mem_cnt_q;
  logic [CW-1:0]     occupancy;
  logic              out_valid_q;
  logic [255:0]      out_data_q;
  logic [ID_W-1:0]   out_tid_q;

  logic sink_hs;
  logic push;
  logic pop_mem;
  logic fifo_full;

  // Occupancy counts the output register too, so a full buffer means
  // OUT_FIFO_DEPTH digests are waiting in total.
  assign occupancy = mem_cnt_q + CW'(out_valid_q);
  assign fifo_full = (occupancy == CW'(OUT_FIFO_DEPTH));

  assign axis_sink.tready = !areset && (state_q == IDLE) && !fifo_full;
  assign sink_hs          = axis_sink.tvalid && axis_sink.tready;
  assign push             = (state_q == UPDATE) && last_q;
  assign pop_mem          = (mem_cnt_q != '0) && (!out_valid_q || axis_src.tready);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_in_words
      assign blk_words[gi] = bswap32(axis_sink.tdata[32*gi +: 32]);
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_digest
      assign h_sum[gi]           = h_q[gi] + work_q[gi];
      assign digest[32*gi +: 32] = bswap32(h_sum[gi]);
    end
  endgenerate

  sha256_round_unit #(
    .ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)
  ) u_round (
    .state_i  (work_q),
    .window_i (win_q),
    .round_i  (rnd_q),
    .state_o  (work_d),
    .window_o (win_d)
  );

  // Block FSM: latch a block, run the rounds, fold into H and finish messages.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      h_q      <= IV;
      work_q   <= '0;
      win_q    <= '0;
      rnd_q    <= '0;
      last_q   <= 1'b0;
      in_msg_q <= 1'b0;
      tid_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sink_hs) begin
            win_q  <= blk_words;
            work_q <= h_q;
            last_q <= axis_sink.tlast;
            rnd_q  <= '0;
            // A message's tid comes from its first block only.
            if (!in_msg_q) tid_q <= axis_sink.tid;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          work_q <= work_d;
          win_q  <= win_d;
          rnd_q  <= rnd_q + 6'(ROUNDS_PER_CYCLE);
          if (rnd_q == 6'(64 - ROUNDS_PER_CYCLE)) state_q <= UPDATE;
        end
        UPDATE: begin
          h_q      <= last_q ? IV : h_sum;
          in_msg_q <= !last_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Digest storage write port (no reset so it maps onto RAM).
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= {tid_q, digest};
  end

  // Buffer pointers plus the registered read that feeds the source stream.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tid_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_mem) begin
        rd_ptr_q                <= rd_ptr_q + PW'(1);
        {out_tid_q, out_data_q} <= mem_q[rd_ptr_q];
        out_valid_q             <= 1'b1;
      end else if (axis_src.tready) begin
        out_valid_q <= 1'b0;
      end
      mem_cnt_q <= mem_cnt_q + CW'(push) - CW'(pop_mem);
    end
  end

  assign axis_src.tvalid = out_valid_q;
  assign axis_src.tdata  = {256'h0, out_data_q};
  assign axis_src.tkeep  = 64'h0000_0000_FFFF_FFFF;
  assign axis_src.tlast  = 1'b1;
  assign axis_src.tid    = out_tid_q;

  assign busy = (state_q != IDLE) || (occupancy != '0);

`ifdef SHA256_STATS_EN
  logic [CNT_BITS-1:0] msg_cnt_q;
  logic [CNT_BITS-1:0] blk_cnt_q;

  // Free-running status counters, wrapping naturally.
  always_ff @(posedge aclk) begin
    if (areset) begin
      msg_cnt_q <= '0;
      blk_cnt_q <= '0;
    end else begin
      if (push)    msg_cnt_q <= msg_cnt_q + CNT_BITS'(1);
      if (sink_hs) blk_cnt_q <= blk_cnt_q + CNT_BITS'(1);
    end
  end

  assign msg_count = msg_cnt_q;
  assign blk_count = blk_cnt_q;
`else
  assign msg_count = '0;
  assign blk_count = '0;
`endif

endmodule
